// File: rtl/ysyx_24110015_ifu_pkg.sv
// ysyx_24110015_ifu_pkg: shared FSM encoding and entry sizing for the prefetching IFU
package ysyx_24110015_ifu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALT} ifu_state_e;
  function automatic int entry_w(input int xlen);
    return 2 * xlen + 1;
  endfunction
endpackage

// File: rtl/ysyx_24110015_ifu_mem_if.sv
// ysyx_24110015_ifu_mem_if: single-outstanding request/response instruction memory port
interface ysyx_24110015_ifu_mem_if #(parameter int XLEN = 32);
  logic req_valid, req_ready, rsp_valid, rsp_err;
  logic [XLEN-1:0] req_addr, rsp_data;
  modport master(output req_valid, req_addr, input req_ready, rsp_valid, rsp_data, rsp_err);
  modport slave(input req_valid, req_addr, output req_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/ysyx_24110015_ifu_fifo.sv
// ysyx_24110015_ifu_fifo: synchronous FIFO with flush; a push in the flush cycle lands in the emptied buffer
module ysyx_24110015_ifu_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] rp_q, rp_d, wp_q, wp_d, wa;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pop_ok;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // pointer and occupancy update; flush wins over pop but not over push
  always_comb begin
    pop_ok = pop && cnt_q != '0;
    wa = flush ? '0 : wp_q;
    wp_d = push ? inc(wa) : wa;
    rp_d = flush ? '0 : pop_ok ? inc(rp_q) : rp_q;
    cnt_d = (flush ? '0 : cnt_q - CW'(pop_ok)) + CW'(push);
  end
  // state registers; storage itself needs no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q <= '0;
      wp_q <= '0;
      cnt_q <= '0;
    end else begin
      rp_q <= rp_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
    end
    if (push) mem_q[wa] <= din;
  end
  assign head = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/ysyx_24110015_ifu_prefetch.sv
// ysyx_24110015_ifu_prefetch: sequential fetch with one outstanding request, redirect flush and instruction buffer
module ysyx_24110015_ifu_prefetch import ysyx_24110015_ifu_pkg::*; #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 'h8000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_en,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  ysyx_24110015_ifu_mem_if.master      mem,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [XLEN-1:0]              inst,
  output logic [XLEN-1:0]              inst_pc,
  output logic                         inst_fault
);
  localparam int EW = entry_w(XLEN);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  ifu_state_e state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, addr_q, addr_d, push_pc, push_inst;
  logic drop_q, drop_d, flush, push, push_fault, pop, mis;
  logic [CW-1:0] cnt;
  logic [CW:0] cnt_n;
  logic [EW-1:0] head;
  assign pop = inst_valid && inst_ready;
  assign mis = redirect_pc[1:0] != 2'b00;
  assign mem.req_valid = state_q == S_REQ;
  assign mem.req_addr = addr_q;
  // next-state: redirect first, then the sequential fetch protocol; the bus address only moves on entry to REQ
  always_comb begin
    state_d = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d = addr_q;
    drop_d = drop_q;
    flush = 1'b0;
    push = 1'b0;
    push_pc = addr_q;
    push_inst = mem.rsp_err ? '0 : mem.rsp_data;
    push_fault = mem.rsp_err;
    cnt_n = {1'b0, cnt};
    if (redirect_valid) begin
      flush = 1'b1;
      fetch_pc_d = redirect_pc;
      push = mis;
      push_pc = redirect_pc;
      push_inst = '0;
      push_fault = 1'b1;
      if (state_q == S_REQ) begin
        drop_d = 1'b1;
        state_d = mem.req_ready ? S_WAIT : S_REQ;
      end else if (state_q == S_WAIT && !mem.rsp_valid) begin
        drop_d = 1'b1;
      end else begin
        drop_d = 1'b0;
        state_d = mis ? S_HALT : S_REQ;
        addr_d = redirect_pc;
      end
    end else begin
      case (state_q)
        S_IDLE: if (fetch_en && {1'b0, cnt} < DEPTH_C) begin
          state_d = S_REQ;
          addr_d = fetch_pc_q;
        end
        S_REQ: if (mem.req_ready) begin
          state_d = S_WAIT;
          fetch_pc_d = drop_q ? fetch_pc_q : fetch_pc_q + XLEN'(4);
        end
        S_WAIT: if (mem.rsp_valid) begin
          drop_d = 1'b0;
          push = !drop_q;
          addr_d = fetch_pc_q;
          cnt_n = {1'b0, cnt} + (CW + 1)'(!drop_q) - (CW + 1)'(pop);
          state_d = (!drop_q && mem.rsp_err) || (drop_q && fetch_pc_q[1:0] != 2'b00) ? S_HALT :
                    fetch_en && cnt_n < DEPTH_C ? S_REQ : S_IDLE;
        end
        default: ;
      endcase
    end
  end
  // control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q <= addr_d;
      drop_q <= drop_d;
    end
  end
  ysyx_24110015_ifu_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .pop(pop),
    .din({push_pc, push_inst, push_fault}), .head(head), .count(cnt)
  );
  assign inst_valid = cnt != '0;
  assign inst_pc = inst_valid ? head[EW-1:XLEN+1] : '0;
  assign inst = inst_valid ? head[XLEN:1] : '0;
  assign inst_fault = inst_valid && head[0];
endmodule

// File: tb/tb_ysyx_24110015_ifu_prefetch.sv
// tb_ysyx_24110015_ifu_prefetch: randomized bench against a stream-level fetch model
module tb_ysyx_24110015_ifu_prefetch;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, fetch_en = 0, redirect_valid = 0, inst_ready = 0;
  logic [31:0] redirect_pc = 0, inst, inst_pc;
  logic inst_valid, inst_fault;
  ysyx_24110015_ifu_mem_if #(.XLEN(32)) mem();
  ysyx_24110015_ifu_prefetch #(.XLEN(32), .RESET_PC(32'h8000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem(mem), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
  );
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int epoch = 0, pres_ep = 0, out_ep = -1, occ = 0, cyc = 0, out_due = 0;
  int rr_pct = 100, ir_pct = 100, lat_min = 1, lat_x = 0, n_acc = 0, n_pop = 0;
  logic [31:0] req_pc = 32'h8000_0000, exp_pc = 32'h8000_0000, out_addr = 0, hold_addr = 0;
  logic [31:0] err_addr = 0, first_acc = 0, last_pc = 0;
  logic halted = 0, hold = 0, out_v = 0, err_on = 0, last_fault = 0, seen_zero = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    return a[1:0] != 2'b00 || (err_on && a == err_addr);
  endfunction

  task automatic tick();
    logic rv, rr, iv, ir, rsp, rd, mis, st_acc, st_rsp, ef;
    logic [31:0] ra, rdpc;
    @(negedge clk);
    rv = mem.req_valid; ra = mem.req_addr; rr = mem.req_ready; rsp = mem.rsp_valid;
    iv = inst_valid; ir = inst_ready; rd = redirect_valid; rdpc = redirect_pc;
    mis = rdpc[1:0] != 2'b00;
    if (hold) begin
      chk("req_hold_valid", rv, 1);
      chk("req_hold_addr", ra, hold_addr);
    end
    chk("inst_valid", iv, occ > 0);
    if (!iv) chk("idle_zero", inst_pc | inst | {31'b0, inst_fault}, 0);
    if (iv && ir && !rd) begin
      ef = is_err(exp_pc);
      chk("pop_pc", inst_pc, exp_pc);
      chk("pop_inst", inst, ef ? 32'h0 : mem_word(exp_pc));
      chk("pop_fault", inst_fault, ef);
    end
    if (rv && !hold) pres_ep = epoch;
    st_acc = pres_ep != epoch || rd;
    if (rv && rr && !st_acc) begin
      chk("req_addr", ra, req_pc);
      chk("req_while_halted", halted, 0);
      chk("req_slot", occ < DEPTH, 1);
      if (n_acc == 0) first_acc = ra;
      if (ra == 0) seen_zero = 1;
      n_acc++;
    end
    st_rsp = out_ep != epoch || rd;
    @(posedge clk);
    if (rsp) begin
      out_v = 0;
      if (!st_rsp) begin
        occ++;
        if (is_err(out_addr)) halted = 1;
      end
    end
    if (iv && ir && !rd) begin
      occ--;
      last_pc = exp_pc;
      last_fault = is_err(exp_pc);
      exp_pc += 4;
      n_pop++;
    end
    if (rv && rr) begin
      out_v = 1;
      out_addr = ra;
      out_ep = st_acc ? -1 : epoch;
      out_due = cyc + lat_min + $urandom_range(0, lat_x);
      if (!st_acc) req_pc += 4;
    end
    if (rd) begin
      epoch++;
      occ = mis ? 1 : 0;
      halted = mis;
      req_pc = rdpc;
      exp_pc = rdpc;
    end
    hold = rv && !rr;
    hold_addr = ra;
    cyc++;
    #1;
    mem.rsp_valid = out_v && cyc >= out_due;
    mem.rsp_data = mem.rsp_valid ? mem_word(out_addr) : 32'h0;
    mem.rsp_err = mem.rsp_valid && is_err(out_addr);
    mem.req_ready = $urandom_range(0, 99) < rr_pct;
    inst_ready = $urandom_range(0, 99) < ir_pct;
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc = pc;
    tick();
    redirect_valid = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic zero_counts();
    n_acc = 0;
    n_pop = 0;
    seen_zero = 0;
  endtask

  initial begin
    logic [31:0] pc;
    int sel;
    mem.req_ready = 1; mem.rsp_valid = 0; mem.rsp_data = 0; mem.rsp_err = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_req_valid", mem.req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_fields", inst_pc | inst | {31'b0, inst_fault}, 0);
    run(3);
    chk("no_fetch_when_disabled", mem.req_valid, 0);
    fetch_en = 1;
    zero_counts();
    run(20);
    chk("seq_first_addr", first_acc, 32'h8000_0000);
    chk("seq_throughput", n_pop >= 8, 1);
    ir_pct = 0;
    redir(32'h8000_0100);
    zero_counts();
    run(30);
    chk("full_stop_reqs", n_acc, 2);
    ir_pct = 100;
    tick();
    ir_pct = 0;
    zero_counts();
    run(20);
    chk("one_pop_one_req", n_acc, 1);
    chk("one_pop_count", n_pop, 1);
    ir_pct = 100;
    lat_min = 4;
    for (int k = 0; k < 20 && !out_v; k++) tick();
    chk("wait_inflight", out_v, 1);
    redir(32'h8000_1000);
    zero_counts();
    run(20);
    chk("wait_redir_first", first_acc, 32'h8000_1000);
    lat_min = 1;
    rr_pct = 0;
    for (int k = 0; k < 20 && !mem.req_valid; k++) tick();
    chk("stall_req_seen", mem.req_valid, 1);
    tick();
    redir(32'h8000_2000);
    tick();
    rr_pct = 100;
    zero_counts();
    run(20);
    chk("stall_redir_first", first_acc, 32'h8000_2000);
    err_on = 1;
    err_addr = 32'h8000_0008;
    redir(32'h8000_0000);
    zero_counts();
    run(30);
    chk("err_reqs", n_acc, 3);
    chk("err_pops", n_pop, 3);
    chk("err_last_pc", last_pc, 32'h8000_0008);
    chk("err_last_fault", last_fault, 1);
    err_on = 0;
    redir(32'h8000_0002);
    zero_counts();
    run(10);
    chk("mis_reqs", n_acc, 0);
    chk("mis_pops", n_pop, 1);
    chk("mis_pc", last_pc, 32'h8000_0002);
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    chk("redir_latency_valid", mem.req_valid, 1);
    chk("redir_latency_addr", mem.req_addr, 32'hFFFF_FFFC);
    zero_counts();
    run(12);
    chk("wrap_to_zero", seen_zero, 1);
    zero_counts();
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        rr_pct = $urandom_range(30, 100);
        ir_pct = $urandom_range(30, 100);
        lat_x = $urandom_range(0, 3);
        fetch_en = $urandom_range(0, 9) != 0;
      end
      if ($urandom_range(0, 24) == 0) begin
        sel = $urandom_range(0, 9);
        pc = sel == 0 ? 32'hFFFF_FFF0 : {16'h8000, 14'($urandom), 2'b00};
        if (sel == 1) pc[1:0] = 2'($urandom_range(1, 3));
        err_on = sel >= 8;
        err_addr = pc + 32'(4 * $urandom_range(1, 6));
        redir(pc);
      end else tick();
    end
    chk("random_progress", n_pop > 200, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
